nios2_oci_mem_sequencer: RTL and testbench

//  Arbitrates one single-port on-chip debug RAM (OCI memory) between two requesters.

---
 rtl/nios2_oci_mem_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_nios2_oci_mem_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_oci_mem_sequencer.sv
// OCI debug RAM sequencer: arbitrates JTAG and Avalon requesters
// onto one single-port RAM and returns JTAG results to the monitor.
module nios2_oci_mem_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [37:0]       jdo,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [ADDR_W-1:0] av_address,
  input  logic [DATA_W-1:0] av_writedata,
  output logic              av_waitrequest,
  output logic [DATA_W-1:0] av_readdata,
  output logic              ram_en,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RDWAIT,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic              grant_jtag;
  logic              grant_jtag_nx;
  logic              last_jtag;
  logic              last_jtag_nx;
  logic [1:0]        cnt;
  logic [1:0]        cnt_nx;
  logic              capture;
  logic              jtag_start;

  logic [ADDR_W-1:0] ptr;
  logic              jtag_pending;
  logic              jtag_wr;
  logic [ADDR_W-1:0] jtag_addr;
  logic [DATA_W-1:0] jtag_wdata;
  logic [DATA_W-1:0] rdata_q;

  logic              av_req;
  logic              jtag_busy;
  logic              b_ok;
  logic              b_drop;
  logic              op_wr;
  logic              jtag_done;
  logic [ADDR_W-1:0] jdo_addr;
  logic [ADDR_W-1:0] ptr_eff;
  logic [DATA_W-1:0] rd_data;
  logic [31:0]       rd_ext;
  logic              unused_jdo;

  assign av_req    = av_read | av_write;
  assign jtag_busy = jtag_pending
                   | ((state != IDLE) & grant_jtag);
  assign b_ok      = take_action_ocimem_b & ~jtag_busy;
  assign b_drop    = take_action_ocimem_b & jtag_busy;
  assign jdo_addr  = jdo[ADDR_W+16:17];
  assign ptr_eff   = take_action_ocimem_a ? jdo_addr : ptr;
  assign op_wr     = grant_jtag ? jtag_wr : av_write;
  assign jtag_done = (state == DONE) & grant_jtag;
  assign rd_data   = (RD_LAT == 1) ? ram_rdata : rdata_q;

  assign ram_en    = (state == ACCESS);
  assign ram_wr    = (state == ACCESS) & op_wr;
  assign ram_addr  = grant_jtag ? jtag_addr : av_address;
  assign ram_wdata = grant_jtag ? jtag_wdata : av_writedata;

  assign av_readdata    = rd_data;
  assign av_waitrequest = av_req
                        & ~((state == DONE) & ~grant_jtag);

  assign unused_jdo = ^jdo;

  // zero-extend read data into the 32-bit monitor register
  always_comb begin
    rd_ext = '0;
    rd_ext[DATA_W-1:0] = rd_data;
  end

  // state, grant and read-latency counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant_jtag <= 1'b0;
      last_jtag  <= 1'b0;
      cnt        <= '0;
    end else begin
      state      <= state_nx;
      grant_jtag <= grant_jtag_nx;
      last_jtag  <= last_jtag_nx;
      cnt        <= cnt_nx;
    end
  end

  // next state: round-robin grant, one-cycle access, read wait
  always_comb begin
    state_nx      = state;
    grant_jtag_nx = grant_jtag;
    last_jtag_nx  = last_jtag;
    cnt_nx        = cnt;
    capture       = 1'b0;
    jtag_start    = 1'b0;
    unique case (state)
      IDLE: begin
        if (jtag_pending | av_req) begin
          state_nx      = ACCESS;
          grant_jtag_nx = jtag_pending
                        & (~av_req | ~last_jtag);
          last_jtag_nx  = grant_jtag_nx;
          jtag_start    = grant_jtag_nx;
        end
      end
      ACCESS: begin
        if (op_wr || RD_LAT == 1) begin
          state_nx = DONE;
        end else begin
          state_nx = RDWAIT;
          cnt_nx   = 2'(RD_LAT - 1);
        end
      end
      RDWAIT: begin
        if (cnt == 2'd0) begin
          capture  = 1'b1;
          state_nx = DONE;
        end else begin
          cnt_nx = cnt - 2'd1;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // JTAG request capture and address pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr          <= '0;
      jtag_pending <= 1'b0;
      jtag_wr      <= 1'b0;
      jtag_addr    <= '0;
      jtag_wdata   <= '0;
    end else begin
      if (take_action_ocimem_a) begin
        ptr <= jdo_addr;
      end else if (jtag_done) begin
        ptr <= ptr + 1'b1;
      end
      if (b_ok) begin
        jtag_pending <= 1'b1;
        jtag_wr      <= jdo[35];
        jtag_addr    <= ptr_eff;
        jtag_wdata   <= jdo[DATA_W+2:3];
      end else if (jtag_start) begin
        jtag_pending <= 1'b0;
      end
    end
  end

  // read data capture and JTAG monitor results
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q       <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      if (capture) begin
        rdata_q <= ram_rdata;
      end
      if (jtag_done) begin
        monitor_ready <= 1'b1;
        if (!jtag_wr) begin
          MonDReg <= rd_ext;
        end
      end else if (b_ok) begin
        monitor_ready <= 1'b0;
      end
      if (b_drop) begin
        monitor_error <= 1'b1;
      end else if (take_action_ocimem_a) begin
        monitor_error <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nios2_oci_mem_sequencer.sv
// Directed bench for nios2_oci_mem_sequencer with a
// behavioural 2-cycle-latency RAM attached.
module tb_nios2_oci_mem_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        take_a = 1'b0;
  logic        take_b = 1'b0;
  logic [37:0] jdo = '0;
  logic        av_read = 1'b0;
  logic        av_write = 1'b0;
  logic [7:0]  av_address = '0;
  logic [31:0] av_writedata = '0;
  logic        av_waitrequest;
  logic [31:0] av_readdata;
  logic        ram_en;
  logic        ram_wr;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  int total = 0;
  int bad = 0;
  int n_acc = 0;

  logic [31:0] mem [256] = '{default: 32'h0};
  logic [31:0] p1 = '0;
  logic [31:0] p2 = '0;

  always #5 clk = ~clk;

  nios2_oci_mem_sequencer #(
    .ADDR_W(8),
    .DATA_W(32),
    .RD_LAT(2)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .take_action_ocimem_a(take_a),
    .take_action_ocimem_b(take_b),
    .jdo                 (jdo),
    .av_read             (av_read),
    .av_write            (av_write),
    .av_address          (av_address),
    .av_writedata        (av_writedata),
    .av_waitrequest      (av_waitrequest),
    .av_readdata         (av_readdata),
    .ram_en              (ram_en),
    .ram_wr              (ram_wr),
    .ram_addr            (ram_addr),
    .ram_wdata           (ram_wdata),
    .ram_rdata           (ram_rdata),
    .MonDReg             (MonDReg),
    .monitor_ready       (monitor_ready),
    .monitor_error       (monitor_error)
  );

  // RAM model: write on strobe, read data two cycles later
  always @(posedge clk) begin
    if (ram_en && ram_wr) mem[ram_addr] <= ram_wdata;
    p1 <= mem[ram_addr];
    p2 <= p1;
    if (ram_en) n_acc <= n_acc + 1;
  end
  assign ram_rdata = p2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] jaddr(input logic [7:0] a);
    return 38'(a) << 17;
  endfunction

  function automatic logic [37:0] jwr(input logic [31:0] d);
    return {2'b00, 1'b1, d, 3'b000};
  endfunction

  initial begin
    int n0;
    int lows;

    tick();
    tick();
    chk("rst_mondreg", MonDReg, 0);
    chk("rst_ready", monitor_ready, 0);
    chk("rst_error", monitor_error, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_wait", av_waitrequest, 0);
    reset_n = 1'b1;
    tick();

    // 1: load pointer 0x10, JTAG write
    take_a = 1'b1;
    jdo = jaddr(8'h10);
    tick();
    take_a = 1'b0;
    take_b = 1'b1;
    jdo = jwr(32'hDEADBEEF);
    tick();
    take_b = 1'b0;
    chk("t1_no_en_yet", ram_en, 0);
    tick();
    chk("t1_en", ram_en, 1);
    chk("t1_wr", ram_wr, 1);
    chk("t1_addr", ram_addr, 8'h10);
    chk("t1_wdata", ram_wdata, 32'hDEADBEEF);
    tick();
    chk("t1_ready_lo", monitor_ready, 0);
    tick();
    chk("t1_ready_hi", monitor_ready, 1);
    chk("t1_mem", mem[8'h10], 32'hDEADBEEF);

    // 2: pointer load and read in same cycle
    take_a = 1'b1;
    take_b = 1'b1;
    jdo = jaddr(8'h10);
    tick();
    take_a = 1'b0;
    take_b = 1'b0;
    chk("t2_ready_clr", monitor_ready, 0);
    tick();
    chk("t2_en", ram_en, 1);
    chk("t2_rd", ram_wr, 0);
    chk("t2_addr", ram_addr, 8'h10);
    tick();
    tick();
    tick();
    chk("t2_ready_done", monitor_ready, 0);
    tick();
    chk("t2_mondreg", MonDReg, 32'hDEADBEEF);
    chk("t2_ready_hi", monitor_ready, 1);

    // Avalon write 0x20
    av_write = 1'b1;
    av_address = 8'h20;
    av_writedata = 32'hCAFE0020;
    #1;
    chk("aw_wait_hi", av_waitrequest, 1);
    tick();
    chk("aw_en", ram_en, 1);
    chk("aw_wr", ram_wr, 1);
    chk("aw_addr", ram_addr, 8'h20);
    tick();
    chk("aw_wait_lo", av_waitrequest, 0);
    tick();
    av_write = 1'b0;

    // 3: JTAG read (ptr 0x11) ties with Avalon read 0x20
    take_b = 1'b1;
    jdo = '0;
    tick();
    take_b = 1'b0;
    av_read = 1'b1;
    av_address = 8'h20;
    lows = 0;
    for (int i = 2; i <= 10; i++) begin
      tick();
      if (!av_waitrequest) lows++;
      if (i == 2) begin
        chk("t3_jtag_first", ram_addr, 8'h11);
        chk("t3_jtag_en", ram_en, 1);
      end
      if (i == 7) begin
        chk("t3_av_en", ram_en, 1);
        chk("t3_av_addr", ram_addr, 8'h20);
      end
      if (i == 10) begin
        chk("t3_av_wait", av_waitrequest, 0);
        chk("t3_av_data", av_readdata, 32'hCAFE0020);
      end
    end
    chk("t3_wait_once", lows, 1);
    chk("t3_mondreg", MonDReg, 0);
    chk("t3_ready", monitor_ready, 1);
    tick();
    av_read = 1'b0;

    // 4: overrun while first access pending
    take_b = 1'b1;
    jdo = jwr(32'h11111111);
    tick();
    jdo = jwr(32'h22222222);
    n0 = n_acc;
    tick();
    take_b = 1'b0;
    chk("t4_error", monitor_error, 1);
    chk("t4_addr", ram_addr, 8'h12);
    chk("t4_wdata", ram_wdata, 32'h11111111);
    for (int i = 0; i < 4; i++) tick();
    chk("t4_one_access", n_acc - n0, 1);
    chk("t4_mem", mem[8'h12], 32'h11111111);
    chk("t4_ready", monitor_ready, 1);
    take_a = 1'b1;
    jdo = jaddr(8'hFF);
    tick();
    take_a = 1'b0;
    chk("t4_err_clr", monitor_error, 0);

    // 5: pointer wrap at 0xFF
    take_b = 1'b1;
    jdo = jwr(32'hA5A5A5A5);
    tick();
    take_b = 1'b0;
    tick();
    chk("t5_addr_ff", ram_addr, 8'hFF);
    chk("t5_wr", ram_wr, 1);
    tick();
    tick();
    take_b = 1'b1;
    jdo = '0;
    tick();
    take_b = 1'b0;
    tick();
    chk("t5_en", ram_en, 1);
    chk("t5_addr_00", ram_addr, 8'h00);
    for (int i = 0; i < 4; i++) tick();
    chk("t5_mem", mem[8'hFF], 32'hA5A5A5A5);
    chk("t5_ready", monitor_ready, 1);

    // 6: reset during Avalon read wait
    av_read = 1'b1;
    av_address = 8'h20;
    tick();
    chk("t6_en", ram_en, 1);
    tick();
    chk("t6_wait", av_waitrequest, 1);
    reset_n = 1'b0;
    av_read = 1'b0;
    #1;
    chk("t6_rst_en", ram_en, 0);
    chk("t6_rst_ready", monitor_ready, 0);
    chk("t6_rst_error", monitor_error, 0);
    chk("t6_rst_mon", MonDReg, 0);
    chk("t6_rst_wait", av_waitrequest, 0);
    tick();
    reset_n = 1'b1;
    tick();
    av_write = 1'b1;
    av_address = 8'h30;
    av_writedata = 32'h12345678;
    #1;
    chk("t6_aw_wait_hi", av_waitrequest, 1);
    tick();
    chk("t6_aw_en", ram_en, 1);
    chk("t6_aw_addr", ram_addr, 8'h30);
    tick();
    chk("t6_aw_wait_lo", av_waitrequest, 0);
    tick();
    av_write = 1'b0;
    tick();
    chk("t6_mem", mem[8'h30], 32'h12345678);
    chk("t6_mem_kept", mem[8'h20], 32'hCAFE0020);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
